// File: rtl/mult_pkg.sv
// Shared widths, Dadda stage heights and the half-adder helper used by the
// 8x8 partial-product reduction tree.
package mult_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  // Maximum column height after each Dadda reduction stage.
  localparam int DADDA_H1 = 6;
  localparam int DADDA_H2 = 4;
  localparam int DADDA_H3 = 3;
  localparam int DADDA_H4 = 2;

  // Returns {carry, sum}.
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

endpackage

// File: rtl/mult_fa.sv
// One-bit full adder, the basic 3:2 counter of the reduction tree.
module mult_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/multiplier_fast_pipe.sv
// Unsigned 8x8 Dadda-tree multiplier: combinational product plus one
// registered copy qualified by a valid flag.
module multiplier_fast_pipe
  import mult_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  input  logic              in_valid,
  output logic [PROD_W-1:0] product,
  output logic [PROD_W-1:0] product_q,
  output logic              out_valid
);

  // pp[i][j] = a[j] & b[i], weight i+j.
  logic [OP_W-1:0] pp [OP_W];

  for (genvar i = 0; i < OP_W; i++) begin : g_pp
    assign pp[i] = a & {OP_W{b[i]}};
  end

  // Stage 0 columns, bit 0 holding the lowest row index.
  logic       c0_0;
  logic [1:0] c0_1;
  logic [2:0] c0_2;
  logic [3:0] c0_3;
  logic [4:0] c0_4;
  logic [5:0] c0_5;
  logic [6:0] c0_6;
  logic [7:0] c0_7;
  logic [6:0] c0_8;
  logic [5:0] c0_9;
  logic [4:0] c0_10;
  logic [3:0] c0_11;
  logic [2:0] c0_12;
  logic [1:0] c0_13;
  logic       c0_14;

  assign c0_0  = pp[0][0];
  assign c0_1  = {pp[1][0], pp[0][1]};
  assign c0_2  = {pp[2][0], pp[1][1], pp[0][2]};
  assign c0_3  = {pp[3][0], pp[2][1], pp[1][2], pp[0][3]};
  assign c0_4  = {pp[4][0], pp[3][1], pp[2][2], pp[1][3], pp[0][4]};
  assign c0_5  = {pp[5][0], pp[4][1], pp[3][2], pp[2][3], pp[1][4], pp[0][5]};
  assign c0_6  = {pp[6][0], pp[5][1], pp[4][2], pp[3][3], pp[2][4], pp[1][5], pp[0][6]};
  assign c0_7  = {pp[7][0], pp[6][1], pp[5][2], pp[4][3], pp[3][4], pp[2][5], pp[1][6], pp[0][7]};
  assign c0_8  = {pp[7][1], pp[6][2], pp[5][3], pp[4][4], pp[3][5], pp[2][6], pp[1][7]};
  assign c0_9  = {pp[7][2], pp[6][3], pp[5][4], pp[4][5], pp[3][6], pp[2][7]};
  assign c0_10 = {pp[7][3], pp[6][4], pp[5][5], pp[4][6], pp[3][7]};
  assign c0_11 = {pp[7][4], pp[6][5], pp[5][6], pp[4][7]};
  assign c0_12 = {pp[7][5], pp[6][6], pp[5][7]};
  assign c0_13 = {pp[7][6], pp[6][7]};
  assign c0_14 = pp[7][7];

  // Each new column is {carries from w-1, sums of w, untouched bits of w}.
  // Stage 1: height 8 -> 6, only columns 6..10 change.
  logic [DADDA_H1-1:0] c1 [6:10];
  logic       s1_6, y1_6, s1_9, y1_9;
  logic [1:0] s1_7, y1_7, s1_8, y1_8;

  assign {y1_6, s1_6} = half_add(c0_6[0], c0_6[1]);
  mult_fa u_s1_7 (.a(c0_7[0]), .b(c0_7[1]), .cin(c0_7[2]), .s(s1_7[0]), .cout(y1_7[0]));
  assign {y1_7[1], s1_7[1]} = half_add(c0_7[3], c0_7[4]);
  mult_fa u_s1_8 (.a(c0_8[0]), .b(c0_8[1]), .cin(c0_8[2]), .s(s1_8[0]), .cout(y1_8[0]));
  assign {y1_8[1], s1_8[1]} = half_add(c0_8[3], c0_8[4]);
  mult_fa u_s1_9 (.a(c0_9[0]), .b(c0_9[1]), .cin(c0_9[2]), .s(s1_9), .cout(y1_9));

  assign c1[6]  = {s1_6, c0_6[6:2]};
  assign c1[7]  = {y1_6, s1_7, c0_7[7:5]};
  assign c1[8]  = {y1_7, s1_8, c0_8[6:5]};
  assign c1[9]  = {y1_8, s1_9, c0_9[5:3]};
  assign c1[10] = {y1_9, c0_10};

  // Stage 2: height 6 -> 4, columns 4..12 change.
  logic [DADDA_H2-1:0] c2 [4:12];
  logic       s2_4, y2_4, s2_11, y2_11;
  logic [1:0] s2 [5:10];
  logic [1:0] y2 [5:10];

  assign {y2_4, s2_4} = half_add(c0_4[0], c0_4[1]);
  mult_fa u_s2_5 (.a(c0_5[0]), .b(c0_5[1]), .cin(c0_5[2]), .s(s2[5][0]), .cout(y2[5][0]));
  assign {y2[5][1], s2[5][1]} = half_add(c0_5[3], c0_5[4]);

  for (genvar w = 6; w <= 10; w++) begin : g_s2
    mult_fa u_lo (.a(c1[w][0]), .b(c1[w][1]), .cin(c1[w][2]), .s(s2[w][0]), .cout(y2[w][0]));
    mult_fa u_hi (.a(c1[w][3]), .b(c1[w][4]), .cin(c1[w][5]), .s(s2[w][1]), .cout(y2[w][1]));
    assign c2[w] = {y2[w-1], s2[w]};
  end

  mult_fa u_s2_11 (.a(c0_11[0]), .b(c0_11[1]), .cin(c0_11[2]), .s(s2_11), .cout(y2_11));

  assign c2[4]  = {s2_4, c0_4[4:2]};
  assign c2[5]  = {y2_4, s2[5], c0_5[5]};
  assign c2[11] = {y2[10], s2_11, c0_11[3]};
  assign c2[12] = {y2_11, c0_12};

  // Stage 3: height 4 -> 3, columns 3..13 change.
  logic [DADDA_H3-1:0] c3 [3:13];
  logic [12:3] s3, y3;

  assign {y3[3], s3[3]} = half_add(c0_3[0], c0_3[1]);
  assign c3[3] = {s3[3], c0_3[3:2]};

  for (genvar w = 4; w <= 12; w++) begin : g_s3
    mult_fa u_fa (.a(c2[w][0]), .b(c2[w][1]), .cin(c2[w][2]), .s(s3[w]), .cout(y3[w]));
    assign c3[w] = {y3[w-1], s3[w], c2[w][3]};
  end

  assign c3[13] = {y3[12], c0_13};

  // Stage 4: height 3 -> 2, columns 2..14 change.
  logic [DADDA_H4-1:0] c4 [2:14];
  logic [13:2] s4, y4;

  assign {y4[2], s4[2]} = half_add(c0_2[0], c0_2[1]);
  assign c4[2] = {s4[2], c0_2[2]};

  for (genvar w = 3; w <= 13; w++) begin : g_s4
    mult_fa u_fa (.a(c3[w][0]), .b(c3[w][1]), .cin(c3[w][2]), .s(s4[w]), .cout(y4[w]));
    assign c4[w] = {y4[w-1], s4[w]};
  end

  assign c4[14] = {y4[13], c0_14};

  // Two 15-bit rows into the final carry-propagate adder.
  logic [PROD_W-2:0] row_a, row_b;

  // NOTE: every always_comb output gets a default first so no path can
  // leave a bit unassigned and infer a latch.
  always_comb begin
    row_a    = '0;
    row_b    = '0;
    row_a[0] = c0_0;
    row_a[1] = c0_1[0];
    row_b[1] = c0_1[1];
    for (int w = 2; w < PROD_W - 1; w++) begin
      row_a[w] = c4[w][0];
      row_b[w] = c4[w][1];
    end
  end

  assign product = {1'b0, row_a} + {1'b0, row_b};

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product_q <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) product_q <= product;
    end
  end

endmodule

// File: tb/tb_multiplier_fast_pipe.sv
// Directed, random and registered-path checks for multiplier_fast_pipe.
module tb_multiplier_fast_pipe;
  import mult_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [OP_W-1:0]   a, b;
  logic              in_valid;
  logic [PROD_W-1:0] product, product_q;
  logic              out_valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [OP_W-1:0]   a;
    logic [OP_W-1:0]   b;
    logic [PROD_W-1:0] p;
  } vec_t;

  vec_t vecs [16];

  multiplier_fast_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .product   (product),
    .product_q (product_q),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [OP_W-1:0]   ra, rb;
    logic [PROD_W-1:0] rexp;
    logic [OP_W-1:0]   s_op  [4];
    logic [PROD_W-1:0] s_exp [4];

    vecs[0]  = '{8'd1,   8'd255, 16'd255};
    vecs[1]  = '{8'd5,   8'd10,  16'd50};
    vecs[2]  = '{8'd15,  8'd15,  16'd225};
    vecs[3]  = '{8'd127, 8'd2,   16'd254};
    vecs[4]  = '{8'd255, 8'd255, 16'd65025};
    vecs[5]  = '{8'd0,   8'd0,   16'd0};
    vecs[6]  = '{8'd0,   8'd200, 16'd0};
    vecs[7]  = '{8'd200, 8'd0,   16'd0};
    vecs[8]  = '{8'd128, 8'd128, 16'd16384};
    vecs[9]  = '{8'd255, 8'd1,   16'd255};
    vecs[10] = '{8'd170, 8'd85,  16'd14450};
    vecs[11] = '{8'd85,  8'd170, 16'd14450};
    vecs[12] = '{8'd254, 8'd255, 16'd64770};
    vecs[13] = '{8'd3,   8'd171, 16'd513};
    vecs[14] = '{8'd255, 8'd128, 16'd32640};
    vecs[15] = '{8'd16,  8'd16,  16'd256};

    s_op  = '{8'd2, 8'd3, 8'd4, 8'd16};
    s_exp = '{16'd4, 16'd9, 16'd16, 16'd256};

    rst_n = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    #2 rst_n = 1'b0;
    #1;
    check("reset_q",     product_q, 32'd0);
    check("reset_valid", out_valid, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Combinational table.
    for (int i = 0; i < 16; i++) begin
      a = vecs[i].a; b = vecs[i].b;
      #1;
      check($sformatf("vec%0d_%0dx%0d", i, vecs[i].a, vecs[i].b), product, vecs[i].p);
    end

    // Random combinational pairs.
    for (int i = 0; i < 2000; i++) begin
      ra = OP_W'($urandom_range(0, 255));
      rb = OP_W'($urandom_range(0, 255));
      rexp = {8'd0, ra} * {8'd0, rb};
      a = ra; b = rb;
      #1;
      check($sformatf("rand_%0dx%0d", ra, rb), product, rexp);
    end

    // Registered capture and hold.
    @(negedge clk); a = 8'd200; b = 8'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    check("reg_valid", out_valid, 32'd1);
    check("reg_q",     product_q, 32'd600);
    @(negedge clk); in_valid = 1'b0; a = 8'd7; b = 8'd9;
    @(posedge clk); #1;
    check("hold_valid", out_valid, 32'd0);
    check("hold_q",     product_q, 32'd600);
    check("hold_comb",  product,   32'd63);

    // Asynchronous reset between edges with a valid input in flight.
    @(negedge clk); a = 8'd12; b = 8'd11; in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_q",     product_q, 32'd0);
    check("async_rst_valid", out_valid, 32'd0);
    check("async_rst_comb",  product,   32'd132);
    @(posedge clk); #1;
    check("in_rst_q",     product_q, 32'd0);
    check("in_rst_valid", out_valid, 32'd0);
    @(negedge clk); rst_n = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst_valid", out_valid, 32'd0);
    check("post_rst_q",     product_q, 32'd0);
    @(negedge clk); a = 8'd255; b = 8'd255; in_valid = 1'b1;
    @(posedge clk); #1;
    check("max_q",     product_q, 32'hFE01);
    check("max_valid", out_valid, 32'd1);

    // Back-to-back streaming.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); a = s_op[i]; b = s_op[i]; in_valid = 1'b1;
      @(posedge clk); #1;
      check($sformatf("stream%0d_q", i),     product_q, s_exp[i]);
      check($sformatf("stream%0d_valid", i), out_valid, 32'd1);
    end
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1;
    check("stream_end_valid", out_valid, 32'd0);
    check("stream_end_q",     product_q, 32'd256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiplier_fast_pipe.md
# multiplier_fast_pipe

Unsigned 8×8 → 16-bit integer multiplier built as an explicit partial-product reduction tree, for datapath use where a combinational product is consumed in the same cycle. The block also provides a single registered copy of the product with a valid flag, so downstream logic can choose zero-latency or one-cycle-registered results. This is the fast alternative to the iterative shift-add multiplier.

## Interface
- Parameters: none. Operand width is fixed at 8 and product width at 16.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  input  1  rising-edge clock for the output register.
- rst_n  input  1  asynchronous active-low reset.
- a  input  8  unsigned multiplicand.
- b  input  8  unsigned multiplier.
- in_valid  input  1  qualifies a/b for capture into the output register.
- product  output  16  combinational a×b, with no clock dependency.
- product_q  output  16  registered product.
- out_valid  output  1  registered in_valid.

## Operation
- Generate 64 partial-product bits pp[i][j] = a[j] & b[i] at weight i+j.
- Reduce the partial-product columns to two rows using a Dadda tree of full and half adders, with stage heights 6, 4, 3, 2.
- Sum the two rows in a 16-bit final carry-propagate adder. The carry-out above bit 15 is always 0 and is discarded.
- The behavioural `*` operator is not allowed in the datapath.
- The result is exact unsigned arithmetic:
  - maximum 255×255 = 65025 (0xFE01);
  - any operand equal to 0 gives 0;
  - no overflow is possible.
- product is a pure function of a and b. It does not depend on clk, rst_n or in_valid, and it carries no state.
- On each rising clk edge:
  - out_valid <= in_valid.
  - If in_valid = 1, product_q <= product; otherwise product_q holds its value.
- Back-to-back valid inputs are accepted every cycle. There is no backpressure and no stall input.

## Timing
- product: zero-cycle latency. It must settle within 1 ns of an input change in simulation, using zero-delay RTL.
- product_q and out_valid: latency of 1 cycle from the edge that samples in_valid = 1.
- Reset:
  - While rst_n is low: product_q = 0x0000 and out_valid = 0, applied immediately (asynchronous).
  - product keeps tracking a×b during reset.
- Reset asserted mid-stream: the in-flight result is discarded, and out_valid is 0 on the first edge after rst_n deasserts unless in_valid is 1 at that edge.
- Reset deassertion is synchronised externally. The block assumes rst_n release meets recovery/removal timing to clk.
- There are no X outputs for known inputs. Outputs after reset never show X.

## Structure
- Shared package mult_pkg:
  - OP_W = 8 and PROD_W = 16;
  - the Dadda stage height constants (6, 4, 3, 2).
- Natural sub-module: mult_fa, a 1-bit full adder (a, b, cin → s, cout). It is instantiated throughout the reduction tree.
- Half adders and the final adder may be inline.
- Expected top-level RTL size is 150–300 lines, dominated by explicit tree wiring.

## Test plan
- Directed combinational vectors, checking product 1 ns after each change:
  - 1×255 → 255;
  - 5×10 → 50;
  - 15×15 → 225;
  - 127×2 → 254;
  - 255×255 → 65025;
  - 0×0 → 0.
- Random: 2000 pairs of a and b, each compared with a×b 1 ns after application; any mismatch is an error.
- Registered path:
  - Drive in_valid = 1 with a = 200, b = 3. After 1 edge: out_valid = 1 and product_q = 600.
  - Next cycle drive in_valid = 0. Then out_valid = 0 and product_q holds 600.
- Reset:
  - Assert rst_n = 0 asynchronously between edges. product_q = 0 and out_valid = 0 immediately, while product still equals a×b.
  - Release rst_n, then pulse in_valid = 1 with a = 255, b = 255. Then product_q = 0xFE01.
- Streaming: apply valid inputs on 4 consecutive cycles (2×2, 3×3, 4×4, 16×16). product_q must equal 4, 9, 16, 256 on the following 4 cycles, with out_valid = 1 on all of them.
